// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, NZCV flags and the request record seen by the issue scheduler.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_LSL = 4'd5,
    ALU_LSR = 4'd6,
    ALU_ASR = 4'd7
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        setf;
  } alu_req_t;

  localparam alu_op_t ALU_OP_LAST = ALU_ASR;

  // Any encoding past the last defined opcode is accepted but flagged as an error.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > 4'(ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a registered pointer with wrap.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  always_comb begin
    grant  = '0;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = PW'(idx);
        found      = 1'b1;
      end
    end
    ptr_next = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
  end

  // The pointer only moves past a requester that was actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one external combinational ALU between requesters via an issue slot and a response slot,
// and owns the architectural APSR NZCV register.
module alu_issue_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_setf,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [DATA_W-1:0]     resp_result,
  output logic [3:0]            resp_flags,
  output logic                  resp_err,
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [3:0]            alu_flags,
  output logic [3:0]            apsr_flags,
  output logic                  busy
);

  localparam int OW = $clog2(NUM_REQ);

  logic              i_valid, i_setf;
  logic [OW-1:0]     i_owner;
  logic [3:0]        i_op;
  logic [DATA_W-1:0] i_a, i_b;

  logic              r_valid, r_err;
  logic [OW-1:0]     r_owner;
  logic [DATA_W-1:0] r_result;
  alu_flags_t        r_flags;
  alu_flags_t        apsr;

  logic [NUM_REQ-1:0] grant;
  logic [OW-1:0]      rr_ptr_unused;
  logic               r_free, i_adv, accept, i_illegal;

  logic [OW-1:0]     win_idx;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              sel_setf;

  assign r_free    = !r_valid || resp_ready[r_owner];
  assign i_adv     = i_valid && r_free;
  assign accept    = (!i_valid || i_adv) && (|req_valid) && !rst;
  assign i_illegal = op_is_illegal(i_op);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant),
    .ptr     (rr_ptr_unused)
  );

  assign req_ready = accept ? grant : '0;

  always_comb begin
    win_idx  = '0;
    sel_op   = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_setf = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = OW'(i);
        sel_op   = req_op[4*i +: 4];
        sel_a    = req_a[DATA_W*i +: DATA_W];
        sel_b    = req_b[DATA_W*i +: DATA_W];
        sel_setf = req_setf[i];
      end
    end
  end

  // Issue slot refills in the same cycle it hands its operation to the response slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_valid <= 1'b0;
      i_owner <= '0;
      i_op    <= '0;
      i_a     <= '0;
      i_b     <= '0;
      i_setf  <= 1'b0;
    end else if (accept) begin
      i_valid <= 1'b1;
      i_owner <= win_idx;
      i_op    <= sel_op;
      i_a     <= sel_a;
      i_b     <= sel_b;
      i_setf  <= sel_setf;
    end else if (i_adv) begin
      i_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_owner  <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
    end else if (i_adv) begin
      r_valid  <= 1'b1;
      r_owner  <= i_owner;
      r_result <= i_illegal ? '0 : alu_result;
      r_flags  <= alu_flags_t'(alu_flags);
      r_err    <= i_illegal;
    end else if (r_valid && resp_ready[r_owner]) begin
      r_valid <= 1'b0;
    end
  end

  // Illegal operations never touch the architectural flags, whatever setf says.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apsr <= '0;
    end else if (i_adv && i_setf && !i_illegal) begin
      apsr <= alu_flags_t'(alu_flags);
    end
  end

  always_comb begin
    resp_valid = '0;
    if (r_valid) resp_valid[r_owner] = 1'b1;
  end

  assign resp_result = r_result;
  assign resp_flags  = r_flags;
  assign resp_err    = r_err;
  assign alu_op      = i_op;
  assign alu_a       = i_a;
  assign alu_b       = i_b;
  assign apsr_flags  = apsr;
  assign busy        = i_valid | r_valid;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: reference ALU, response scoreboard, vector table and corner sequences.
module tb_alu_issue_scheduler;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_setf, resp_valid, resp_ready;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0]   resp_result, alu_a, alu_b, alu_result;
  logic [3:0]     resp_flags, alu_op, alu_flags, apsr_flags;
  logic           resp_err, busy;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_setf(req_setf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .apsr_flags(apsr_flags), .busy(busy)
  );

  // Reference ALU: {result, N, Z, C, V}; C is carry-out for ADD and no-borrow for SUB.
  function automatic logic [35:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'($signed(a) >>> b[4:0]);
      default: return {32'hDEAD_BEEF, 4'b1001};
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  always_comb {alu_result, alu_flags} = refAlu(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [N-1:0] owner_oh;
    logic [31:0]  result;
    logic [3:0]   flags;
    logic         err;
  } exp_t;

  typedef struct {
    int          owner;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        setf;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
    logic [3:0]  apsr;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];
  int   nChecks = 0;
  int   nFails  = 0;
  int   nResp   = 0;
  int   acc     = 0;
  int   order[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: expectations are pushed on accepted requests and popped on completed responses.
  always @(negedge clk) begin : scoreboard
    exp_t        e;
    logic [35:0] r;
    if (rst) begin
      sbq.delete();
    end else begin
      if (|(resp_valid & resp_ready)) begin
        if (sbq.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL sb_unexpected: got response %b, expected none", resp_valid);
        end else begin
          e = sbq.pop_front();
          checkOutput("sb_owner", 64'(resp_valid), 64'(e.owner_oh));
          checkOutput("sb_result", 64'(resp_result), 64'(e.result));
          checkOutput("sb_flags", 64'(resp_flags), 64'(e.flags));
          checkOutput("sb_err", 64'(resp_err), 64'(e.err));
          nResp++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r          = refAlu(req_op[4*i +: 4], req_a[W*i +: W], req_b[W*i +: W]);
          e.owner_oh = N'(1) << i;
          e.err      = req_op[4*i + 3];
          e.result   = e.err ? 32'd0 : r[35:4];
          e.flags    = r[3:0];
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic applyStimulus(input int owner, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic setf);
    req_valid[owner]     = 1'b1;
    req_op[4*owner +: 4] = op;
    req_a[W*owner +: W]  = a;
    req_b[W*owner +: W]  = b;
    req_setf[owner]      = setf;
  endtask

  task automatic clearRequests();
    req_valid = '0;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    clearRequests();
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic waitAccepts(input int target, input bit clearAtEnd);
    int c = 0;
    while (acc < target && c < 40) begin
      @(negedge clk);
      if (|req_ready) begin
        if (acc < 8) order[acc] = req_ready[1] ? 1 : 0;
        acc++;
      end
      @(posedge clk); #1;
      if (acc >= target && clearAtEnd) clearRequests();
      c++;
    end
    checkOutput("accept_count", 64'(acc), 64'(target));
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    bit   got;
    vecs[0] = '{0, 4'd0,    32'd5,          32'd3,      1'b1, 32'd8,          4'b0000, 1'b0, 4'b0000};
    vecs[1] = '{1, 4'd1,    32'd3,          32'd3,      1'b1, 32'd0,          4'b0110, 1'b0, 4'b0110};
    vecs[2] = '{0, 4'b1010, 32'd7,          32'd9,      1'b1, 32'd0,          4'b1001, 1'b1, 4'b0110};
    vecs[3] = '{0, 4'd1,    32'd0,          32'd1,      1'b0, 32'hFFFF_FFFF,  4'b1000, 1'b0, 4'b0110};
    vecs[4] = '{1, 4'd0,    32'h7FFF_FFFF,  32'd1,      1'b1, 32'h8000_0000,  4'b1001, 1'b0, 4'b1001};
    vecs[5] = '{0, 4'd2,    32'h0000_F0F0,  32'h0FF0,   1'b0, 32'h0000_00F0,  4'b0000, 1'b0, 4'b1001};
    vecs[6] = '{1, 4'd5,    32'd1,          32'd31,     1'b1, 32'h8000_0000,  4'b1000, 1'b0, 4'b1000};
    vecs[7] = '{0, 4'd7,    32'h8000_0000,  32'd4,      1'b0, 32'hF800_0000,  4'b1000, 1'b0, 4'b1000};
    vecs[8] = '{1, 4'd0,    32'hFFFF_FFFF,  32'd1,      1'b1, 32'd0,          4'b0110, 1'b0, 4'b0110};

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_setf = '0; resp_ready = '0;
    repeat (2) @(posedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_apsr", 64'(apsr_flags), 64'd0);
    checkOutput("rst_alu_op", 64'(alu_op), 64'd0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_resp_result", 64'(resp_result), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table: one operation at a time, checking latency, response fields and APSR.
    resp_ready = 2'b11;
    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      applyStimulus(v.owner, v.op, v.a, v.b, v.setf);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (req_ready[v.owner]) got = 1'b1;
      end
      checkOutput("vec_accept", 64'(got), 64'd1);
      @(posedge clk); #1;
      clearRequests();
      @(negedge clk);
      checkOutput("vec_resp_early", 64'(resp_valid), 64'd0);
      checkOutput("vec_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("vec_resp_valid", 64'(resp_valid), 64'(N'(1) << v.owner));
      checkOutput("vec_result", 64'(resp_result), 64'(v.res));
      checkOutput("vec_flags", 64'(resp_flags), 64'(v.flg));
      checkOutput("vec_err", 64'(resp_err), 64'(v.err));
      @(posedge clk); #1;
      checkOutput("vec_apsr", 64'(apsr_flags), 64'(v.apsr));
    end

    // Reset while both slots hold operations.
    resp_ready = 2'b00;
    applyStimulus(0, 4'd0, 32'd1, 32'd2, 1'b0);
    applyStimulus(1, 4'd1, 32'd4, 32'd1, 1'b0);
    acc = 0;
    waitAccepts(2, 1'b1);
    @(negedge clk);
    checkOutput("mid_busy_before", 64'(busy), 64'd1);
    checkOutput("mid_resp_before", 64'(|resp_valid), 64'd1);
    checkOutput("mid_apsr_before", 64'(apsr_flags), 64'b0110);
    #1 rst = 1'b1;
    sbq.delete();
    #1;
    checkOutput("mid_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_apsr", 64'(apsr_flags), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("mid_no_resp", 64'(resp_valid), 64'd0);
    end

    // Round-robin under continuous contention; first grant after reset goes to requester 0.
    @(posedge clk); #1;
    applyStimulus(0, 4'd0, 32'd10, 32'd1, 1'b0);
    applyStimulus(1, 4'd1, 32'd3, 32'd3, 1'b1);
    acc = 0;
    waitAccepts(6, 1'b1);
    for (int i = 0; i < 6; i++) checkOutput("rr_order", 64'(order[i]), 64'(i % 2));
    waitIdle();
    checkOutput("rr_sb_empty", 64'(sbq.size()), 64'd0);
    checkOutput("rr_apsr", 64'(apsr_flags), 64'b0110);

    // Backpressure: stalled response holds both slots and blocks new accepts.
    resetDut();
    resp_ready = 2'b00;
    nResp = 0;
    applyStimulus(0, 4'd0, 32'd1, 32'd1, 1'b0);
    applyStimulus(1, 4'd1, 32'd5, 32'd2, 1'b0);
    acc = 0;
    waitAccepts(2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_resp_valid", 64'(resp_valid), 64'b01);
      checkOutput("bp_result", 64'(resp_result), 64'd2);
      checkOutput("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    waitAccepts(4, 1'b1);
    waitIdle();
    checkOutput("bp_resp_count", 64'(nResp), 64'd4);
    checkOutput("bp_sb_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
